mitll_not_array: RTL
====================

# mitll_not_array

Parametrised, multi-channel, cycle-based successor to the single clocked SFQ inverter model. Each of N channels receives an RSFQ data pulse stream, all channels share one SFQ clock pulse stream, and pulses are toggle-encoded: every level change is one pulse. A channel emits an output pulse on an SFQ clock pulse only when no data pulse arrived since the previous SFQ clock pulse. The block also flags critical-timing and illegal-state violations per channel, and sits in the sampled netlist-level simulation fabric beside the other mitll_* cell models.

## Interface
- N, 4: channel count (≥1)
- DELAY, 9: SFQ-clock-to-output latency in sample cycles (≥1)
- CT_IN, 2: data critical window after an emitting SFQ clock, in cycles (≥1)
- CT_CLK, 8: clock-to-clock critical window after an emitting SFQ clock, in cycles (≥1)
- SETTLE, 4: cycles after reset during which detected pulses are ignored
- ERRCNT_W, 8: error counter width (used only with the counter feature)
- clk  in  1  sample clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- sfq_clk_t  in  1  toggle-encoded SFQ clock pulse stream, shared by all channels
- in_t  in  N  toggle-encoded data pulse streams, one per channel
- out_t  out  N  toggle-encoded output pulses
- err  out  N  sticky per-channel violation flag
- err_any  out  1  OR of err
- err_cnt  out  N*ERRCNT_W  per-channel saturating violation count (present only with the macro)

## Operation
- Pulse detect: each input has a history register. A pulse in cycle k is input(k) ≠ history(k−1).
- Channel state: S0 (idle, no data since last SFQ clock) or S1 (data seen).
- Data pulse in S0: go to S1. Data pulse in S1: illegal; set err, stay in S1.
- SFQ clock pulse in S1: go to S0 with no output.
- SFQ clock pulse in S0: stay in S0. Schedule an output pulse DELAY cycles later. Open the data window (cycles k..k+CT_IN−1) and the clock window (cycles k+1..k+CT_CLK−1).
- Data pulse inside an open data window: violation. Set err, skip the state update, and let the pending output still fire.
- SFQ clock pulse inside an open clock window: violation. Set err, take no state action, and do not restart the windows.
- Same-cycle data and SFQ clock pulses: evaluate the clock first, against the state at cycle start. Then the data pulse falls in the new data window, so S0 gives output plus violation, and S1 gives S0 plus an illegal data pulse with S1 kept.
- err stays set until rst. No other input clears it.
- SETTLE: for the first SETTLE cycles after rst deasserts, history registers track the inputs and all pulses are ignored.

## Timing
- Reset values: out_t=0, err=0, err_any=0, err_cnt=0, state=S0, windows closed, delay lines empty, settle counter=SETTLE.
- History registers load the current inputs during reset, so no spurious pulse appears at reset release.
- Emitting SFQ clock detected in cycle k: out_t[i] toggles at the clk edge ending cycle k+DELAY−1, visible in cycle k+DELAY.
- Each channel's delay line is a DELAY-deep pulse shift register, so overlapping scheduled pulses are all delivered.
- err sets at the edge ending the violating cycle. err_any is registered in the same cycle as err.
- rst mid-operation: pending pulses are discarded and windows close. The next settle period starts when rst deasserts.

## Configuration
- MITLL_NOT_ARRAY_ERRCNT_EN defined: err_cnt port exists. Each violation increments the channel counter, which saturates at 2^ERRCNT_W−1. Two violations in one cycle (data window plus illegal) count as one.
- Not defined: no counter logic and no err_cnt port. All other behaviour is identical.

## Structure
- Package mitll_pkg holds:
  - the channel state enum (S0/S1)
  - the violation cause enum (CT_IN, CT_CLK, ILLEGAL)
  - a clog2-based width helper for the window counters
- Sub-module mitll_not_chan holds one channel: state, data-window counter, clock-window counter, delay line, err, optional counter.
- The top level holds the shared SFQ clock pulse detect, the settle counter and the generate loop.

## Test plan
- Reset, SFQ clock pulse at cycle 10, no data → out_t[0] toggles in cycle 19; err=0.
- Data pulse on ch1 at cycle 10, SFQ clock pulse at 20 → no ch1 output; ch1 back in S0; a second SFQ clock pulse at 40 → ch1 output in cycle 49.
- SFQ clock pulse at 10 (S0), data on ch2 at 11 → err[2]=1, err_any=1, and the output in cycle 19 is still delivered.
- SFQ clock pulses at 10 and 15 → err on all N channels, one output only. With the macro, err_cnt=1 on each channel.
- Two data pulses on ch3 at 30 and 32 with no SFQ clock between → err[3]=1 (illegal data pulse in S1).
- in_t=4'hF held through rst, then rst deasserted, with toggles at cycles 1–3 after release → no state change and no err. After assertion of rst at cycle 5 of an in-flight pulse, out_t stays 0.

Source files
------------

// File: rtl/mitll_pkg.sv
// Shared types and helpers for the mitll_* sampled SFQ cell models.
package mitll_pkg;

    typedef enum logic {
        S0 = 1'b0,
        S1 = 1'b1
    } chan_state_e;

    typedef enum logic [1:0] {
        CAUSE_CT_IN   = 2'd0,
        CAUSE_CT_CLK  = 2'd1,
        CAUSE_ILLEGAL = 2'd2
    } viol_cause_e;

    localparam int unsigned N_CAUSE = 3;

    // Bits needed to hold a counter value in 0..max_val (never less than one).
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mitll_not_chan.sv
// One clocked SFQ inverter channel: state, timing windows, output delay line, sticky error.
// Optional saturating violation counter under MITLL_NOT_ARRAY_ERRCNT_EN.
module mitll_not_chan
    import mitll_pkg::*;
#(
    parameter int unsigned DELAY  = 9,
    parameter int unsigned CT_IN  = 2,
    parameter int unsigned CT_CLK = 8
`ifdef MITLL_NOT_ARRAY_ERRCNT_EN
    ,
    parameter int unsigned ERRCNT_W = 8
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clk_p,
    input  logic                i_dat_p,
    output logic                o_out_t,
    output logic                o_err,
`ifdef MITLL_NOT_ARRAY_ERRCNT_EN
    output logic [ERRCNT_W-1:0] o_err_cnt,
`endif
    output logic                o_viol_c
);

    localparam int unsigned DIN_W = cnt_w(CT_IN);
    localparam int unsigned CLK_W = cnt_w(CT_CLK);

    chan_state_e          r_state;
    chan_state_e          w_state_mid;
    chan_state_e          w_state_nxt;
    logic [DIN_W-1:0]     r_din_cnt;
    logic [CLK_W-1:0]     r_clk_cnt;
    logic [N_CAUSE-1:0]   w_viol;
    logic                 w_emit;
    logic                 w_fire;
    logic                 r_out;
    logic                 r_err;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S0;
        else     r_state <= w_state_nxt;
    end

    // Clock pulse is resolved first against the cycle-start state; the data
    // pulse then sees the data window the clock may have just opened.
    always_comb begin
        w_viol      = '0;
        w_emit      = 1'b0;
        w_state_mid = r_state;
        w_state_nxt = r_state;
        if (i_clk_p) begin
            if (r_clk_cnt != '0)  w_viol[CAUSE_CT_CLK] = 1'b1;
            else if (r_state == S1) w_state_mid = S0;
            else                  w_emit = 1'b1;
        end
        w_state_nxt = w_state_mid;
        if (i_dat_p) begin
            if ((r_din_cnt != '0) || w_emit) begin
                w_viol[CAUSE_CT_IN] = 1'b1;
            end else begin
                if (r_state == S1) w_viol[CAUSE_ILLEGAL] = 1'b1;
                w_state_nxt = S1;
            end
        end
    end

    // Window counters hold the number of remaining open cycles after this one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_din_cnt <= '0;
            r_clk_cnt <= '0;
        end else begin
            if (w_emit)                r_din_cnt <= DIN_W'(CT_IN - 1);
            else if (r_din_cnt != '0)  r_din_cnt <= r_din_cnt - DIN_W'(1);
            if (w_emit)                r_clk_cnt <= CLK_W'(CT_CLK - 1);
            else if (r_clk_cnt != '0)  r_clk_cnt <= r_clk_cnt - CLK_W'(1);
        end
    end

    // The output register is the final stage of the DELAY-deep pulse line.
    generate
        if (DELAY > 1) begin : g_line
            logic [DELAY-2:0] r_dly;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dly <= '0;
                end else begin
                    r_dly[0] <= w_emit;
                    for (int i = 1; i < int'(DELAY) - 1; i++) r_dly[i] <= r_dly[i-1];
                end
            end
            assign w_fire = r_dly[DELAY-2];
        end else begin : g_direct
            assign w_fire = w_emit;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_out <= r_out ^ w_fire;
            r_err <= r_err | (|w_viol);
        end
    end

`ifdef MITLL_NOT_ARRAY_ERRCNT_EN
    logic [ERRCNT_W-1:0] r_err_cnt;

    // Any number of violations in one cycle counts once.
    always_ff @(posedge clk) begin
        if (rst)                               r_err_cnt <= '0;
        else if ((|w_viol) && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
    end

    assign o_err_cnt = r_err_cnt;
`endif

    assign o_out_t  = r_out;
    assign o_err    = r_err;
    assign o_viol_c = |w_viol;

endmodule

// File: rtl/mitll_not_array.sv
// N-channel clocked SFQ inverter array with shared SFQ clock and toggle-encoded pulses.
// Optional per-channel error counters under MITLL_NOT_ARRAY_ERRCNT_EN.
module mitll_not_array
    import mitll_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned DELAY  = 9,
    parameter int unsigned CT_IN  = 2,
    parameter int unsigned CT_CLK = 8,
    parameter int unsigned SETTLE = 4
`ifdef MITLL_NOT_ARRAY_ERRCNT_EN
    ,
    parameter int unsigned ERRCNT_W = 8
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sfq_clk_t,
    input  logic [N-1:0]          in_t,
    output logic [N-1:0]          out_t,
    output logic [N-1:0]          err,
`ifdef MITLL_NOT_ARRAY_ERRCNT_EN
    output logic [N*ERRCNT_W-1:0] err_cnt,
`endif
    output logic                  err_any
);

    localparam int unsigned SET_W = cnt_w(SETTLE);

    logic             r_sfq_h;
    logic [N-1:0]     r_in_h;
    logic [SET_W-1:0] r_settle;
    logic             r_err_any;
    logic             w_live;
    logic             w_sfq_p;
    logic [N-1:0]     w_in_p;
    logic [N-1:0]     w_viol;

    // History registers follow the inputs during reset so release is pulse-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sfq_h  <= sfq_clk_t;
            r_in_h   <= in_t;
            r_settle <= SET_W'(SETTLE);
        end else begin
            r_sfq_h  <= sfq_clk_t;
            r_in_h   <= in_t;
            if (r_settle != '0) r_settle <= r_settle - SET_W'(1);
        end
    end

    assign w_live  = (r_settle == '0);
    assign w_sfq_p = w_live & (sfq_clk_t ^ r_sfq_h);
    assign w_in_p  = {N{w_live}} & (in_t ^ r_in_h);

    // Sticky OR of all channel errors, updated on the same edge as err.
    always_ff @(posedge clk) begin
        if (rst) r_err_any <= 1'b0;
        else     r_err_any <= r_err_any | (|w_viol);
    end

    assign err_any = r_err_any;

    generate
        for (genvar g = 0; g < int'(N); g++) begin : g_chan
            mitll_not_chan #(
                .DELAY    (DELAY),
                .CT_IN    (CT_IN),
`ifdef MITLL_NOT_ARRAY_ERRCNT_EN
                .ERRCNT_W (ERRCNT_W),
`endif
                .CT_CLK   (CT_CLK)
            ) u_chan (
                .clk       (clk),
                .rst       (rst),
                .i_clk_p   (w_sfq_p),
                .i_dat_p   (w_in_p[g]),
                .o_out_t   (out_t[g]),
                .o_err     (err[g]),
`ifdef MITLL_NOT_ARRAY_ERRCNT_EN
                .o_err_cnt (err_cnt[g*ERRCNT_W +: ERRCNT_W]),
`endif
                .o_viol_c  (w_viol[g])
            );
        end
    endgenerate

endmodule
